// File: rtl/neopixel_tx.sv
// WS2812-style bit serializer: shifts pixel words out MSB first as timed high/low
// pulses on a single data line, then holds the line low for the frame latch period.
module neopixel_tx #(
  parameter int CntWidth   = 32,
  parameter int NumWidth   = 32,
  parameter int PixelWidth = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [NumWidth-1:0]   num_neopixel_i,
  input  logic [CntWidth-1:0]   t1h_i,
  input  logic [CntWidth-1:0]   t1l_i,
  input  logic [CntWidth-1:0]   t0h_i,
  input  logic [CntWidth-1:0]   t0l_i,
  input  logic [CntWidth-1:0]   t_latch_i,
  input  logic [PixelWidth-1:0] pixel_i,
  input  logic                  pixel_valid_i,
  output logic                  pixel_ready_o,
  output logic                  data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  underrun_o
);

  localparam int IdxWidth = $clog2(PixelWidth);
  localparam logic [IdxWidth-1:0] MsbIdx = IdxWidth'(PixelWidth - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [NumWidth-1:0]   pix_cnt_q;
  logic [IdxWidth-1:0]   bit_idx_q;
  logic [PixelWidth-1:0] shift_q;

  // Shadows hold (duration - 1) so a programmed 0 and 1 both give one cycle
  // and the all-ones maximum needs no wider counter.
  logic [CntWidth-1:0] t1h_q, t1l_q, t0h_q, t0l_q, t_latch_q;

  function automatic logic [CntWidth-1:0] dur_m1(input logic [CntWidth-1:0] t);
    return (t == '0) ? '0 : t - CntWidth'(1);
  endfunction

  logic phase_done, last_bit, more_pix, cur_bit, next_bit;

  assign phase_done = (cnt_q == '0);
  assign last_bit   = (bit_idx_q == '0);
  assign more_pix   = (pix_cnt_q != '0);
  assign cur_bit    = shift_q[PixelWidth-1];
  assign next_bit   = shift_q[PixelWidth-2];

  // Ready is combinational in the final LOW cycle so back-to-back pixels
  // continue without a gap; it depends only on registered state, never on valid.
  assign pixel_ready_o = (state_q == LOAD) ||
                         ((state_q == LOW) && phase_done && last_bit && more_pix);

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pix_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      t1h_q      <= '0;
      t1l_q      <= '0;
      t0h_q      <= '0;
      t0l_q      <= '0;
      t_latch_q  <= '0;
      data_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            t1h_q      <= dur_m1(t1h_i);
            t1l_q      <= dur_m1(t1l_i);
            t0h_q      <= dur_m1(t0h_i);
            t0l_q      <= dur_m1(t0l_i);
            t_latch_q  <= dur_m1(t_latch_i);
            pix_cnt_q  <= num_neopixel_i;
            underrun_o <= 1'b0;
            busy_o     <= 1'b1;
            if (num_neopixel_i == '0) begin
              cnt_q   <= dur_m1(t_latch_i);
              state_q <= LATCH;
            end else begin
              state_q <= LOAD;
            end
          end
        end

        LOAD: begin
          if (pixel_valid_i) begin
            shift_q   <= pixel_i;
            bit_idx_q <= MsbIdx;
            pix_cnt_q <= pix_cnt_q - NumWidth'(1);
            cnt_q     <= pixel_i[PixelWidth-1] ? t1h_q : t0h_q;
            data_o    <= 1'b1;
            state_q   <= HIGH;
          end
        end

        HIGH: begin
          if (phase_done) begin
            cnt_q   <= cur_bit ? t1l_q : t0l_q;
            data_o  <= 1'b0;
            state_q <= LOW;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end

        LOW: begin
          if (!phase_done) begin
            cnt_q <= cnt_q - CntWidth'(1);
          end else if (!last_bit) begin
            shift_q   <= shift_q << 1;
            bit_idx_q <= bit_idx_q - IdxWidth'(1);
            cnt_q     <= next_bit ? t1h_q : t0h_q;
            data_o    <= 1'b1;
            state_q   <= HIGH;
          end else if (more_pix) begin
            if (pixel_valid_i) begin
              shift_q   <= pixel_i;
              bit_idx_q <= MsbIdx;
              pix_cnt_q <= pix_cnt_q - NumWidth'(1);
              cnt_q     <= pixel_i[PixelWidth-1] ? t1h_q : t0h_q;
              data_o    <= 1'b1;
              state_q   <= HIGH;
            end else begin
              underrun_o <= 1'b1;
              state_q    <= LOAD;
            end
          end else begin
            cnt_q   <= t_latch_q;
            state_q <= LATCH;
          end
        end

        LATCH: begin
          if (phase_done) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/neopixel_tx.md
Name: neopixel_tx

Overview:
- Bit-level serializer for WS2812-style LED strips. Sits downstream of the NeoPixel register block.
- Consumes the timing values (num_neopixel, t1h, t1l, t0h, t0l, t_latch) and a valid/ready stream of pixel words fed by the DMA/FIFO path.
- Drives the single-wire strip data line with exact per-bit high/low durations, then a latch (reset) low period per frame.

Parameters:
- CntWidth, 32, width of all timing counters and timing inputs.
- NumWidth, 32, width of pixel count input and internal pixel counter.
- PixelWidth, 24, bits per pixel word (GRB), sent MSB first.

Ports:
- clk_i  in  1  clock; the block runs on this single clock.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- num_neopixel_i  in  NumWidth  pixels per frame.
- t1h_i, t1l_i, t0h_i, t0l_i  in  CntWidth each  high/low cycles for a 1-bit and a 0-bit.
- t_latch_i  in  CntWidth  latch low cycles at end of frame.
- pixel_i  in  PixelWidth  pixel word.
- pixel_valid_i  in  1  pixel_i valid.
- pixel_ready_o  out  1  block accepts pixel_i this cycle.
- data_o  out  1  strip data line.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at frame end.
- underrun_o  out  1  sticky flag: pixel stream stalled mid-frame.

Behaviour:
- Reset (sampled on a clk_i edge with rst_ni=0):
  - state=IDLE; data_o, busy_o, done_o, pixel_ready_o, underrun_o all 0.
  - Counters, shift register and timing shadows all 0.
  - Reset mid-frame aborts immediately; data_o is low on the next cycle.
- Shadowing: on start_i in IDLE, all timing inputs and num_neopixel_i are captured into shadow registers. Later input changes do not affect the running frame.
- Timing values of 0 are treated as 1; every phase lasts at least one cycle.
- start_i also clears underrun_o. start_i outside IDLE is ignored.
- States:
  - IDLE: data_o=0. On start_i: go to LATCH if num_neopixel_i==0, else go to LOAD.
  - LOAD: data_o=0, pixel_ready_o=1. On pixel_valid_i: load the shift register, set bit index=PixelWidth-1, go to HIGH next cycle. Waiting in LOAD for the first pixel is not an underrun.
  - HIGH: data_o=1 for exactly tXh cycles, where X is the current bit value. Then go to LOW.
  - LOW: data_o=0 for exactly tXl cycles. On the last LOW cycle:
    - If bits remain: shift, go to HIGH.
    - If this is the last bit and pixels remain: assert pixel_ready_o this cycle (combinationally). If pixel_valid_i is high, load it and go to HIGH; the pixel boundary adds no gap cycles. If not, go to LOAD and set underrun_o.
    - If this is the last bit of the last pixel: go to LATCH.
  - LATCH: data_o=0 for t_latch cycles. Then done_o pulses for one cycle and the state returns to IDLE. busy_o drops in the same cycle done_o is high.
- pixel_ready_o is never asserted outside LOAD and the last-LOW-cycle case above. Exactly num_neopixel pixel handshakes occur per frame.
- Pixel counter decrements on each accepted pixel.
- Phase counters are CntWidth bits. A maximum value of 2^CntWidth-1 must not wrap early.
- Latency: first data_o rise occurs 1 cycle after the first pixel handshake. Start-to-LOAD takes 1 cycle.

Test Plan:
- Timing t1h=4, t1l=2, t0h=2, t0l=4, t_latch=10, num=1, pixel 0xA00000 valid immediately after start. Required response:
  - data_o high 4 cycles, low 2 cycles, high 2, low 4, high 4, low 2, then 21 bits of (high 2, low 4).
  - Then 10 low cycles, done_o for 1 cycle, busy_o=0.
- num=3, pixels always valid. Required response:
  - Exactly 72 high pulses.
  - No extra low cycle between pixels: bit-0 low phase stays exactly t0l/t1l.
  - 3 ready handshakes, underrun_o=0.
- num=2, pixel_valid_i withheld 5 cycles after pixel 0 completes. Required response:
  - data_o low for those cycles, underrun_o=1.
  - Frame completes after the pixel arrives.
  - underrun_o stays 1 until the next start_i, which clears it.
- num=0, t_latch=3, start_i. Required response:
  - No pixel_ready_o.
  - busy_o for 3 LATCH cycles, data_o=0, then done_o.
- All timing values 0, pixel 0x800000, num=1. Required response: bit 23 gives high 1 cycle, low 1 cycle; each remaining 0-bit gives high 1, low 1.
- Mid-frame: change t1h_i and pulse start_i. Required response: no effect on the running frame. Then assert rst_ni=0 during HIGH: data_o=0, state IDLE, busy_o=0 on the next cycle.
